// File: rtl/mopshub_rec_pkg.sv
// Shared constants and state encoding for the receive-pending round-robin arbiter.
package mopshub_rec_pkg;

   localparam int N_BUS = 16;
   localparam int SEL_W = 5;
   localparam int CNT_W = 16;
   localparam int PTR_W = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_GRANT = ST_GRANT,
      S_CLEAR = ST_CLEAR
   } arb_state_e;

endpackage

// File: rtl/rec_rr_pick.sv
// Rotating-priority finder: returns the first set bit of mask found by scanning
// upward from ptr and wrapping from 15 back to 0.
module rec_rr_pick
   import mopshub_rec_pkg::*;
(
   input  logic [N_BUS-1:0] mask,
   input  logic [PTR_W-1:0] ptr,
   output logic             any,
   output logic [PTR_W-1:0] idx
);

   logic [2*N_BUS-1:0] doubled;
   logic [N_BUS-1:0]   rotated;
   logic [PTR_W-1:0]   offset;

   // Rotate the mask so ptr lands on bit 0, take the lowest set bit, then map the offset back.
   always_comb begin
      doubled = {mask, mask} >> ptr;
      rotated = doubled[N_BUS-1:0];
      offset  = '0;
      for (int i = N_BUS - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            offset = PTR_W'(i);
         end
      end
      any = |mask;
      idx = offset + ptr;
   end

endmodule

// File: rtl/bus_rec_rr_arbiter.sv
// Round-robin arbiter in front of the 16-bit receive-pending register.
// Grants one bus at a time to the receive handler, then strobes rst_bus_sig with
// bus_rec_select to clear that bus's pending bit. bus_rec_select always stays in 0..15
// so a clear strobe can never wipe the whole pending register.
// Optional feature: define REC_ARB_TIMEOUT_EN to force a release after TIMEOUT_CYCLES
// cycles in GRANT without rec_done (rec_timeout pulses, then the normal clear follows).
module bus_rec_rr_arbiter
   import mopshub_rec_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             arb_en,
   input  logic [N_BUS-1:0] pending_in,
   input  logic             buffer_en,
   input  logic             rec_done,
   output logic             rec_req,
   output logic [SEL_W-1:0] bus_rec_select,
   output logic             rst_bus_sig,
   output logic             arb_busy,
   output logic [CNT_W-1:0] grant_cnt,
   output logic             rec_timeout
);

   arb_state_e       state_q;
   logic [SEL_W-1:0] sel_q;
   logic [PTR_W-1:0] nextPtr_q;
   logic             recReq_q;
   logic             rstBus_q;
   logic [CNT_W-1:0] grantCnt_q;

   logic             pickAny;
   logic [PTR_W-1:0] pickIdx;
   logic             grantEnd_d;

   rec_rr_pick u_pick (
      .mask (pending_in),
      .ptr  (nextPtr_q),
      .any  (pickAny),
      .idx  (pickIdx)
   );

`ifdef REC_ARB_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TMO_W-1:0] tmoCnt_q;
   logic             timeoutHit;
   logic             recTimeout_q;

   assign timeoutHit = (state_q == S_GRANT) && (tmoCnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
   assign grantEnd_d = rec_done || timeoutHit;

   // Count cycles spent in GRANT; held at zero elsewhere so every grant starts fresh.
   always_ff @(posedge clk) begin
      if (rst || state_q != S_GRANT) begin
         tmoCnt_q <= '0;
      end else if (!timeoutHit) begin
         tmoCnt_q <= tmoCnt_q + TMO_W'(1);
      end
   end

   // One-cycle pulse when the grant is released by the timeout rather than by rec_done.
   always_ff @(posedge clk) begin
      if (rst) begin
         recTimeout_q <= 1'b0;
      end else begin
         recTimeout_q <= timeoutHit && !rec_done;
      end
   end

   assign rec_timeout = recTimeout_q;
`else
   assign grantEnd_d  = rec_done;
   assign rec_timeout = 1'b0;
`endif

   // Arbitration FSM: pick in IDLE, hold the grant in GRANT, strobe the clear in CLEAR.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sel_q      <= '0;
         nextPtr_q  <= '0;
         recReq_q   <= 1'b0;
         rstBus_q   <= 1'b0;
         grantCnt_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (arb_en && pickAny) begin
                  sel_q    <= {1'b0, pickIdx};
                  recReq_q <= 1'b1;
                  state_q  <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (grantEnd_d) begin
                  recReq_q  <= 1'b0;
                  rstBus_q  <= 1'b1;
                  nextPtr_q <= sel_q[PTR_W-1:0] + PTR_W'(1);
                  state_q   <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               if (!buffer_en) begin
                  rstBus_q   <= 1'b0;
                  grantCnt_q <= grantCnt_q + CNT_W'(1);
                  state_q    <= S_IDLE;
               end
            end
            default: begin
               recReq_q <= 1'b0;
               rstBus_q <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign rec_req        = recReq_q;
   assign bus_rec_select = sel_q;
   assign rst_bus_sig    = rstBus_q;
   assign arb_busy       = (state_q != S_IDLE);
   assign grant_cnt      = grantCnt_q;

endmodule

// File: tb/tb_bus_rec_rr_arbiter.sv
// Bench for bus_rec_rr_arbiter: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a behavioural reference model.
// The bench also models the receive-pending register itself, driven by buffer_en/loadBits
// and cleared by the DUT's rst_bus_sig/bus_rec_select.
module tb_bus_rec_rr_arbiter;

   localparam int TB_TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        arb_en;
   logic        buffer_en;
   logic        rec_done;
   logic        envClear;
   logic [15:0] loadBits;
   logic [15:0] pendReg = '0;

   logic        rec_req;
   logic [4:0]  bus_rec_select;
   logic        rst_bus_sig;
   logic        arb_busy;
   logic [15:0] grant_cnt;
   logic        rec_timeout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bus_rec_rr_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk            (clk),
      .rst            (rst),
      .arb_en         (arb_en),
      .pending_in     (pendReg),
      .buffer_en      (buffer_en),
      .rec_done       (rec_done),
      .rec_req        (rec_req),
      .bus_rec_select (bus_rec_select),
      .rst_bus_sig    (rst_bus_sig),
      .arb_busy       (arb_busy),
      .grant_cnt      (grant_cnt),
      .rec_timeout    (rec_timeout)
   );

   // Pending register model: loads have priority over the clear strobe from the arbiter.
   always @(posedge clk) begin
      if (envClear) begin
         pendReg <= '0;
      end else if (buffer_en) begin
         pendReg <= pendReg | loadBits;
      end else if (rst_bus_sig) begin
         if (bus_rec_select < 5'd16) begin
            pendReg[bus_rec_select[3:0]] <= 1'b0;
         end else begin
            pendReg <= '0;
         end
      end
   end

   // Reference model state: 0 waiting for work, 1 bus granted, 2 clear strobe active.
   int mPhase   = 0;
   int mSel     = 0;
   int mPtr     = 0;
   int mCnt     = 0;
   int mGrantCy = 0;
   bit mReq     = 1'b0;
   bit mRsb     = 1'b0;
   bit mTmo     = 1'b0;
   bit mValid   = 1'b0;
   bit mTimedOut;

   function automatic int pickBus(input logic [15:0] m, input int p);
      for (int k = 0; k < 16; k++) begin
         if (m[(p + k) % 16]) return (p + k) % 16;
      end
      return -1;
   endfunction

   // Advance the reference model using the values the DUT samples at this edge.
   always @(posedge clk) begin
      if (rst) begin
         mPhase = 0; mSel = 0; mPtr = 0; mCnt = 0; mGrantCy = 0;
         mReq = 1'b0; mRsb = 1'b0; mTmo = 1'b0; mValid = 1'b1;
      end else if (mValid) begin
         mTmo = 1'b0;
         if (mPhase == 0) begin
            if (arb_en && pendReg != 16'h0) begin
               mSel = pickBus(pendReg, mPtr);
               mPhase = 1; mReq = 1'b1; mGrantCy = 0;
            end
         end else if (mPhase == 1) begin
            mGrantCy++;
`ifdef REC_ARB_TIMEOUT_EN
            mTimedOut = !rec_done && (mGrantCy == TB_TIMEOUT);
`else
            mTimedOut = 1'b0;
`endif
            if (rec_done || mTimedOut) begin
               mTmo = mTimedOut;
               mPhase = 2; mReq = 1'b0; mRsb = 1'b1;
               mPtr = (mSel + 1) % 16;
            end
         end else begin
            if (!buffer_en) begin
               mCnt = (mCnt + 1) % 65536;
               mPhase = 0; mRsb = 1'b0;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   // Compare every DUT output against the model once per cycle, away from the active edge.
   always @(negedge clk) begin
      if (mValid) begin
         checkOutput("model rec_req", 32'(rec_req), 32'(mReq));
         checkOutput("model bus_rec_select", 32'(bus_rec_select), 32'(mSel));
         checkOutput("model rst_bus_sig", 32'(rst_bus_sig), 32'(mRsb));
         checkOutput("model arb_busy", 32'(arb_busy), 32'(mPhase != 0));
         checkOutput("model grant_cnt", 32'(grant_cnt), 32'(mCnt));
         checkOutput("model rec_timeout", 32'(rec_timeout), 32'(mTmo));
      end
   end

   task automatic applyStimulus(input logic a, input logic be, input logic [15:0] lb,
                                input logic rd, input logic r);
      arb_en    = a;
      buffer_en = be;
      loadBits  = lb;
      rec_done  = rd;
      rst       = r;
   endtask

   task automatic doReset();
      rst = 1'b1; envClear = 1'b1;
      @(negedge clk);
      rst = 1'b0; envClear = 1'b0;
   endtask

   task automatic loadPending(input logic [15:0] bits);
      buffer_en = 1'b1; loadBits = bits;
      @(negedge clk);
      buffer_en = 1'b0; loadBits = '0;
   endtask

   task automatic waitGrant(input int expBus, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rec_req !== 1'b1 && n < 20);
      if (rec_req !== 1'b1) checkOutput({tag, " grant wait expired"}, 32'(rec_req), 32'd1);
      else                  checkOutput({tag, " grant select"}, 32'(bus_rec_select), 32'(expBus));
   endtask

   task automatic serviceGrant(input int expBus, input string tag);
      rec_done = 1'b1;
      @(negedge clk);
      rec_done = 1'b0;
      checkOutput({tag, " clear strobe"}, 32'(rst_bus_sig), 32'd1);
      checkOutput({tag, " clear select"}, 32'(bus_rec_select), 32'(expBus));
      @(negedge clk);
      checkOutput({tag, " strobe released"}, 32'(rst_bus_sig), 32'd0);
   endtask

   // Safety net: the run must always reach a verdict.
   initial begin
      #2000000;
      failures++;
      $display("[TB] FAIL watchdog: actual=expired required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios, then randomized traffic.
   initial begin
      int highCnt;
      int reqCycles;
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      envClear = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset rec_req", 32'(rec_req), 32'd0);
      checkOutput("reset select", 32'(bus_rec_select), 32'd0);
      checkOutput("reset rst_bus_sig", 32'(rst_bus_sig), 32'd0);
      checkOutput("reset arb_busy", 32'(arb_busy), 32'd0);
      checkOutput("reset grant_cnt", 32'(grant_cnt), 32'd0);
      rst = 1'b0; envClear = 1'b0; arb_en = 1'b1;

      // Single bus: one-cycle grant latency, one-cycle clear, count increments.
      loadPending(16'h0001);
      checkOutput("t1 no grant yet", 32'(rec_req), 32'd0);
      @(negedge clk);
      checkOutput("t1 rec_req", 32'(rec_req), 32'd1);
      checkOutput("t1 select", 32'(bus_rec_select), 32'd0);
      serviceGrant(0, "t1");
      checkOutput("t1 grant_cnt", 32'(grant_cnt), 32'd1);
      checkOutput("t1 pending cleared", 32'(pendReg), 32'd0);

      // Mask 8081 from a fresh pointer: 0, 7, 15 then idle.
      doReset();
      loadPending(16'h8081);
      waitGrant(0, "t2a");  serviceGrant(0, "t2a");
      waitGrant(7, "t2b");  serviceGrant(7, "t2b");
      waitGrant(15, "t2c"); serviceGrant(15, "t2c");
      repeat (2) @(negedge clk);
      checkOutput("t2 idle busy", 32'(arb_busy), 32'd0);
      checkOutput("t2 grant_cnt", 32'(grant_cnt), 32'd3);
      checkOutput("t2 pending empty", 32'(pendReg), 32'd0);

      // Fairness: after bus 7 the pointer sits at 8, so bus 0 wins over bus 7.
      loadPending(16'h0080);
      waitGrant(7, "t3a"); serviceGrant(7, "t3a");
      loadPending(16'h0081);
      waitGrant(0, "t3b"); serviceGrant(0, "t3b");
      waitGrant(7, "t3c"); serviceGrant(7, "t3c");

      // Clear strobe stretched by buffer_en for three CLEAR cycles.
      loadPending(16'h0008);
      waitGrant(3, "t4");
      checkOutput("t4 count before", 32'(grant_cnt), 32'd6);
      rec_done = 1'b1; buffer_en = 1'b1; loadBits = '0;
      highCnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rec_done = 1'b0;
         if (rst_bus_sig === 1'b1) highCnt++;
         if (i == 3) buffer_en = 1'b0;
      end
      checkOutput("t4 strobe cycles", 32'(highCnt), 32'd4);
      checkOutput("t4 count after", 32'(grant_cnt), 32'd7);
      checkOutput("t4 bit 3 cleared", 32'(pendReg[3]), 32'd0);

      // Grant without rec_done.
      loadPending(16'h0004);
      waitGrant(2, "t5");
`ifdef REC_ARB_TIMEOUT_EN
      reqCycles = 1;
      for (int i = 0; i < 50 && rec_timeout !== 1'b1; i++) begin
         @(negedge clk);
         if (rec_req === 1'b1) reqCycles++;
      end
      checkOutput("t5 timeout pulse", 32'(rec_timeout), 32'd1);
      checkOutput("t5 grant cycles", 32'(reqCycles), 32'd8);
      checkOutput("t5 forced clear", 32'(rst_bus_sig), 32'd1);
      @(negedge clk);
      checkOutput("t5 pulse width", 32'(rec_timeout), 32'd0);
`else
      reqCycles = 0;
      repeat (100) begin
         @(negedge clk);
         if (rec_req === 1'b1) reqCycles++;
      end
      checkOutput("t5 grant held", 32'(reqCycles), 32'd100);
      checkOutput("t5 no timeout", 32'(rec_timeout), 32'd0);
      checkOutput("t5 no strobe", 32'(rst_bus_sig), 32'd0);
      serviceGrant(2, "t5");
`endif
      checkOutput("t5 grant_cnt", 32'(grant_cnt), 32'd8);

      // Reset in the middle of a grant leaves the pending bit alone.
      loadPending(16'h0200);
      waitGrant(9, "t6");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("t6 rec_req", 32'(rec_req), 32'd0);
      checkOutput("t6 rst_bus_sig", 32'(rst_bus_sig), 32'd0);
      checkOutput("t6 select", 32'(bus_rec_select), 32'd0);
      checkOutput("t6 grant_cnt", 32'(grant_cnt), 32'd0);
      checkOutput("t6 pending kept", 32'(pendReg[9]), 32'd1);
      waitGrant(9, "t6r"); serviceGrant(9, "t6r");

      // Randomized traffic; the per-cycle model comparison does the checking.
      for (int c = 0; c < 4000; c++) begin
         applyStimulus(($urandom % 8) != 0,
                       ($urandom % 4) == 0,
                       16'($urandom & $urandom & $urandom),
                       ($urandom % 3) == 0,
                       ($urandom % 250) == 0);
         @(negedge clk);
      end
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
